// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ASR = 2'b01,
      OP_PAR = 2'b10,
      OP_UND = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative arithmetic right shifter: a working register shifted one bit per step,
// paired with a down-counter that flags the final step.
module alu_seq_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [CW-1:0]    n_i,
   output logic [WIDTH-1:0] q_o,
   output logic             last_o
);

   logic [WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Load takes priority; a step shifts with sign fill and counts down.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         work_d = a_i;
         cnt_d  = n_i;
      end else if (step_i) begin
         work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         cnt_d  = cnt_q - 1'b1;
      end
   end

   // Working register and counter state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         work_q <= '0;
         cnt_q  <= '0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q_o    = work_q;
   assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with START/DONE handshake: ADD, iterative ASR, PAR, UND.
// Define ALU_SEQ_FLAGS_EN to add the registered zero (Z) and carry (C) flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [1:0]       OPC,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] R,
   output logic             BUSY,
`ifdef ALU_SEQ_FLAGS_EN
   output logic             Z,
   output logic             C,
`endif
   output logic             DONE
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] WidthB   = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    WidthCnt = CW'(WIDTH);

   alu_state_e       state_q;
   logic [WIDTH-1:0] r_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH:0]   sum;
   logic [CW-1:0]    n_sat;
   logic [WIDTH-1:0] imm_res;
   logic             imm_carry;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] asr_last;
   logic             sh_last;
   logic             accept;
   logic             sh_load;
   logic             sh_step;

   // Single-cycle results and shift control decoded from the live operands.
   always_comb begin
      sum       = {1'b0, A} + {1'b0, B};
      n_sat     = (B >= WidthB) ? WidthCnt : B[CW-1:0];
      imm_carry = 1'b0;
      unique case (alu_op_e'(OPC))
         OP_ADD: begin
            imm_res   = sum[WIDTH-1:0];
            imm_carry = sum[WIDTH];
         end
         OP_ASR:  imm_res = A;  // only used when the shift amount is zero
         OP_PAR:  imm_res = {{(WIDTH-1){1'b0}}, ^A};
         default: imm_res = '0;
      endcase
      asr_last = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      accept   = (state_q == IDLE) && START;
      sh_load  = accept && (alu_op_e'(OPC) == OP_ASR) && (n_sat != '0);
      sh_step  = (state_q == SHIFT);
   end

   alu_seq_shifter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_shifter (
      .CLK    (CLK),
      .RST    (RST),
      .load_i (sh_load),
      .step_i (sh_step),
      .a_i    (A),
      .n_i    (n_sat),
      .q_o    (sh_q),
      .last_o (sh_last)
   );

`ifdef ALU_SEQ_FLAGS_EN
   logic z_q;
   logic c_q;
`endif

   // FSM with registered outputs; R and flags change only when entering DONE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
         z_q     <= 1'b0;
         c_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sh_load) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end else if (accept) begin
                  state_q <= alu_pkg::DONE;
                  r_q     <= imm_res;
                  done_q  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                  z_q     <= (imm_res == '0);
                  c_q     <= imm_carry;
`endif
               end
            end
            SHIFT: begin
               if (sh_last) begin
                  state_q <= alu_pkg::DONE;
                  busy_q  <= 1'b0;
                  r_q     <= asr_last;
                  done_q  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                  z_q     <= (asr_last == '0);
                  c_q     <= 1'b0;
`endif
               end
            end
            alu_pkg::DONE: state_q <= IDLE;
            default:       state_q <= IDLE;
         endcase
      end
   end

   assign R    = r_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign Z    = z_q;
   assign C    = c_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32) against an arithmetic model.
module tb_alu_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  opc;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] r;
   logic        busy;
   logic        done;
`ifdef ALU_SEQ_FLAGS_EN
   logic        z;
   logic        c;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq #(
      .WIDTH (32)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .OPC   (opc),
      .A     (a),
      .B     (b),
      .R     (r),
      .BUSY  (busy),
`ifdef ALU_SEQ_FLAGS_EN
      .Z     (z),
      .C     (c),
`endif
      .DONE  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Effective shift amount: B saturated at the word width.
   function automatic int shamt(input logic [31:0] bv);
      return (bv >= 32'd32) ? 32 : int'(bv[5:0]);
   endfunction

   // {carry, result} straight from the opcode definitions.
   function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] av,
                                         input logic [31:0] bv);
      int n;
      n = shamt(bv);
      case (op)
         2'b00:   return {1'b0, av} + {1'b0, bv};
         2'b01: begin
            if (n >= 32) return {1'b0, {32{av[31]}}};
            return {1'b0, 32'($signed(av) >>> n)};
         end
         2'b10:   return {32'b0, ^av};
         default: return 33'b0;
      endcase
   endfunction

   // Issue one operation and check latency, BUSY window, result and flags.
   task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit hold);
      logic [32:0] exp;
      int          exp_busy;
      int          cyc;
      int          busy_cnt;
      exp      = model(op, av, bv);
      exp_busy = (op == 2'b01) ? shamt(bv) : 0;
      @(negedge clk);
      start = 1'b1;
      opc   = op;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      cyc = 1;
      if (!hold) begin
         // Scramble operands so any re-sampling would corrupt the result.
         start = 1'b0;
         opc   = 2'($urandom);
         a     = $urandom;
         b     = $urandom;
      end
      busy_cnt = 0;
      while (!done && cyc < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("done_latency", 64'(cyc), 64'(exp_busy + 1));
      check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      check_eq("busy_at_done", 64'(busy), 64'(0));
      check_eq("result", 64'(r), 64'(exp[31:0]));
`ifdef ALU_SEQ_FLAGS_EN
      check_eq("flag_z", 64'(z), 64'(exp[31:0] == 32'b0));
      check_eq("flag_c", 64'(c), 64'((op == 2'b00) ? exp[32] : 1'b0));
`endif
      if (!hold) begin
         @(posedge clk);
         #1;
         check_eq("done_pulse", 64'(done), 64'(0));
         check_eq("result_hold", 64'(r), 64'(exp[31:0]));
      end
   endtask

   initial begin
      int  k;
      bit  seen_done;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      opc   = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_r", 64'(r), 64'(0));
      check_eq("reset_busy", 64'(busy), 64'(0));
      check_eq("reset_done", 64'(done), 64'(0));
`ifdef ALU_SEQ_FLAGS_EN
      check_eq("reset_z", 64'(z), 64'(0));
      check_eq("reset_c", 64'(c), 64'(0));
`endif
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      run_op(2'b00, 32'd399, 32'd21, 1'b0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(2'b01, 32'hFFFF_0000, 32'd4, 1'b0);
      run_op(2'b01, 32'h8000_0000, 32'd40, 1'b0);
      run_op(2'b01, 32'h7FFF_FFFF, 32'd40, 1'b0);
      run_op(2'b01, 32'h0000_000F, 32'd0, 1'b0);
      run_op(2'b01, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b01, 32'h4000_0000, 32'd31, 1'b0);
      run_op(2'b01, 32'hC000_0003, 32'd1, 1'b0);
      run_op(2'b10, 32'h00FF_01FF, 32'd0, 1'b0);
      run_op(2'b10, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op(2'b10, 32'hFFFE_FFFF, 32'd0, 1'b0);
      run_op(2'b11, 32'd4815, 32'd162342, 1'b0);

      // START held high: no re-accept until the cycle after DONE.
      run_op(2'b01, 32'h8000_0000, 32'd10, 1'b1);
      @(posedge clk);
      #1;
      check_eq("hold_idle_busy", 64'(busy), 64'(0));
      check_eq("hold_idle_done", 64'(done), 64'(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("hold_reaccept", 64'(busy), 64'(1));
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("hold_second_result", 64'(r), 64'(32'hFFE0_0000));
      check_eq("hold_second_done", 64'(done), 64'(1));

      // Reset in cycle 3 of a shift aborts it without a DONE pulse.
      @(negedge clk);
      start = 1'b1;
      opc   = 2'b01;
      a     = 32'h8000_0000;
      b     = 32'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      check_eq("abort_r", 64'(r), 64'(0));
      check_eq("abort_busy", 64'(busy), 64'(0));
      #2;
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      check_eq("abort_no_done", 64'(seen_done), 64'(0));
      check_eq("abort_r_after", 64'(r), 64'(0));
      run_op(2'b01, 32'h8000_0000, 32'd10, 1'b0);

      // Randomised operations.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 40));
            1:       rb = $urandom;
            2:       rb = 32'hFFFF_FFFF;
            default: rb = 32'($urandom_range(0, 5));
         endcase
         run_op(rop, ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
